// File: rtl/ps_pkg.sv
// Shared types and helpers for the parameterised parallel-to-serial converter.
package ps_pkg;

    typedef enum logic {
        StSync,
        StRun
    } ps_state_e;

    localparam logic [7:0] IdleWordDefault = 8'hBC;

    // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Zero-extension does not change the XOR, so callers may pass any word up to 64 bits.
    function automatic logic parity_even(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/ps_fifo.sv
// Synchronous FIFO with a combinational head output; DEPTH must be a power of two.
module ps_fifo
    import ps_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = cnt_width(DEPTH);
    localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (cnt_q == DepthCnt);
    assign empty = (cnt_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // Requests against a full or empty FIFO are ignored here as a second line of defence.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/paralelo_serial_param.sv
// Parameterised parallel-to-serial converter: FIFO-buffered words sent MSB-first, idle-filled.
// Define PARALELO_SERIAL_PARITY_EN to append an even-parity bit to every frame.
module paralelo_serial_param
    import ps_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter int unsigned      DEPTH      = 4,
    parameter logic [WIDTH-1:0] IDLE_WORD  = WIDTH'(IdleWordDefault),
    parameter int unsigned      SYNC_WORDS = 2
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             data_out,
    output logic             word_start,
    output logic             active,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic             overflow
);

`ifdef PARALELO_SERIAL_PARITY_EN
    localparam int unsigned FrameW = WIDTH + 1;
`else
    localparam int unsigned FrameW = WIDTH;
`endif
    localparam int unsigned       CntW     = cnt_width(FrameW);
    localparam logic [CntW-1:0]   LastBit  = CntW'(FrameW - 1);
    localparam int unsigned       SyncW    = cnt_width(SYNC_WORDS + 1);
    localparam logic [SyncW-1:0]  LastSync = SyncW'(SYNC_WORDS - 1);

    ps_state_e        state_q, state_d;
    logic [FrameW-1:0] sr_q, sr_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [SyncW-1:0] sync_cnt_q, sync_cnt_d;
    logic             word_start_q, word_start_d;
    logic             active_q, active_d;
    logic             overflow_q, overflow_d;

    logic             boundary;
    logic             load_data;
    logic             fifo_push;
    logic             fifo_pop;
    logic [WIDTH-1:0] fifo_dout;
    logic [WIDTH-1:0] sym;
    logic [FrameW-1:0] frame;

    ps_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_32f),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (data_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign boundary  = (bit_cnt_q == LastBit);
    // The head is only taken on a boundary, so a word pushed on that same edge waits a symbol.
    assign load_data = boundary && (state_q == StRun) && !fifo_empty;
    assign fifo_pop  = load_data;
    assign fifo_push = valid_in && !fifo_full;
    assign sym       = load_data ? fifo_dout : IDLE_WORD;

`ifdef PARALELO_SERIAL_PARITY_EN
    assign frame = {sym, parity_even(64'(sym))};
`else
    assign frame = sym;
`endif

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q << 1;
        bit_cnt_d  = bit_cnt_q + 1'b1;
        sync_cnt_d = sync_cnt_q;
        active_d   = active_q;
        overflow_d = overflow_q | (valid_in & fifo_full);

        if (boundary) begin
            sr_d      = frame;
            bit_cnt_d = '0;
            active_d  = load_data;
            if (state_q == StSync) begin
                sync_cnt_d = sync_cnt_q + 1'b1;
                if (sync_cnt_q == LastSync) begin
                    state_d = StRun;
                end
            end
        end

        word_start_d = (bit_cnt_d == '0);
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q      <= StSync;
            sr_q         <= '0;
            bit_cnt_q    <= LastBit;
            sync_cnt_q   <= '0;
            word_start_q <= 1'b0;
            active_q     <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            sync_cnt_q   <= sync_cnt_d;
            word_start_q <= word_start_d;
            active_q     <= active_d;
            overflow_q   <= overflow_d;
        end
    end

    assign data_out   = sr_q[FrameW-1];
    assign word_start = word_start_q;
    assign active     = active_q;
    assign overflow   = overflow_q;
    assign ready_out  = !fifo_full;

endmodule

// File: tb/tb_paralelo_serial_param.sv
// Bench for paralelo_serial_param: directed scenarios then random traffic against a queue model.
module tb_paralelo_serial_param;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam logic [7:0] IDLE = 8'hBC;
`ifdef PARALELO_SERIAL_PARITY_EN
    localparam int FW = W + 1;
`else
    localparam int FW = W;
`endif

    logic       clk_32f  = 1'b0;
    logic       reset    = 1'b1;
    logic       valid_in = 1'b0;
    logic [7:0] data_in  = 8'h00;
    logic       ready_out, data_out, word_start, active, fifo_full, fifo_empty, overflow;

    int total = 0;
    int bad   = 0;

    paralelo_serial_param #(
        .WIDTH      (W),
        .DEPTH      (DEPTH),
        .IDLE_WORD  (IDLE),
        .SYNC_WORDS (SYNC)
    ) dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .word_start (word_start),
        .active     (active),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .overflow   (overflow)
    );

    always #5 clk_32f = ~clk_32f;

    // Reference model: n counts edges since reset release; symbol k starts at edge k*FW.
    int         n = 0;
    logic [7:0] cur = 8'h00;
    bit         cur_data = 1'b0;
    logic [7:0] mq[$];
    bit         m_ovf = 1'b0;
    logic       e_dout = 1'b0, e_ws = 1'b0, e_act = 1'b0;

    function automatic logic [63:0] frame_of(input logic [7:0] w);
`ifdef PARALELO_SERIAL_PARITY_EN
        return {55'd0, w, ^w};
`else
        return {56'd0, w};
`endif
    endfunction

    task automatic model_edge(input bit r, input bit v, input logic [7:0] d);
        int sz;
        int b;
        if (r) begin
            mq.delete();
            m_ovf    = 1'b0;
            n        = 0;
            cur      = 8'h00;
            cur_data = 1'b0;
            e_dout   = 1'b0;
            e_ws     = 1'b0;
            e_act    = 1'b0;
            return;
        end
        sz = mq.size();
        b  = n % FW;
        if (b == 0) begin
            if ((n / FW) >= SYNC && sz > 0) begin
                cur      = mq.pop_front();
                cur_data = 1'b1;
            end else begin
                cur      = IDLE;
                cur_data = 1'b0;
            end
        end
        if (v) begin
            if (sz < DEPTH) mq.push_back(d);
            else m_ovf = 1'b1;
        end
        e_dout = (b < W) ? cur[W-1-b] : ^cur;
        e_ws   = (b == 0);
        e_act  = cur_data;
        n++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp, n);
        end
    endtask

    task automatic check_all();
        chk("data_out",   64'(data_out),   64'(e_dout));
        chk("word_start", 64'(word_start), 64'(e_ws));
        chk("active",     64'(active),     64'(e_act));
        chk("fifo_empty", 64'(fifo_empty), 64'(mq.size() == 0));
        chk("fifo_full",  64'(fifo_full),  64'(mq.size() == DEPTH));
        chk("ready_out",  64'(ready_out),  64'(mq.size() != DEPTH));
        chk("overflow",   64'(overflow),   64'(m_ovf));
    endtask

    task automatic step(input bit r, input bit v, input logic [7:0] d);
        reset    = r;
        valid_in = v;
        data_in  = d;
        @(posedge clk_32f);
        model_edge(r, v, d);
        #1;
        check_all();
    endtask

    initial begin
        logic [63:0] got;
        logic [63:0] expv;
        int          cnt;
        int          first_n;
        bit          ok;
        bit          r;
        int          pct;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
        chk("rst_data_out",   64'(data_out),   64'(0));
        chk("rst_word_start", 64'(word_start), 64'(0));
        chk("rst_active",     64'(active),     64'(0));
        chk("rst_fifo_empty", 64'(fifo_empty), 64'(1));
        chk("rst_ready_out",  64'(ready_out),  64'(1));
        chk("rst_overflow",   64'(overflow),   64'(0));

        expv = '0;
        for (int i = 0; i < SYNC; i++) expv = (expv << FW) | frame_of(IDLE);

        got = '0;
        for (int i = 0; i < SYNC * FW; i++) begin
            step(1'b0, 1'b0, 8'h00);
            got = (got << 1) | 64'(data_out);
        end
        chk("sync_pattern", got, expv);

        // Back-to-back burst right after the sync symbols.
        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 8'hDD);
        step(1'b0, 1'b1, 8'hEE);
        got = '0;
        cnt = 0;
        for (int i = 0; i < 5 * FW; i++) begin
            step(1'b0, 1'b0, 8'h00);
            if (active === 1'b1) begin
                cnt++;
                got = (got << 1) | 64'(data_out);
            end
        end
        chk("burst_active_cycles", 64'(cnt), 64'(3 * FW));
        chk("burst_data", got, (((frame_of(8'hFF) << FW) | frame_of(8'hDD)) << FW) | frame_of(8'hEE));

        // Word pushed during the first sync symbol must wait for both idles.
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h30);
        got     = '0;
        cnt     = 0;
        first_n = -1;
        for (int i = 0; i < 5 * FW; i++) begin
            step(1'b0, 1'b0, 8'h00);
            if (active === 1'b1) begin
                if (first_n < 0) first_n = n - 1;
                cnt++;
                got = (got << 1) | 64'(data_out);
            end
        end
        chk("late_first_edge", 64'(first_n), 64'(SYNC * FW));
        chk("late_cycles", 64'(cnt), 64'(FW));
        chk("late_data", got, frame_of(8'h30));

        // Overflow: six pushes mid-data with no boundary in between.
        step(1'b0, 1'b1, 8'hA5);
        ok = 1'b0;
        for (int i = 0; i < 4 * FW && !ok; i++) begin
            step(1'b0, 1'b0, 8'h00);
            ok = cur_data && ((n % FW) == 2);
        end
        chk("ovf_align", 64'(ok), 64'(1));
        for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 8'(i));
        chk("ovf_full",  64'(fifo_full), 64'(1));
        chk("ovf_ready", 64'(ready_out), 64'(0));
        chk("ovf_flag",  64'(overflow),  64'(1));
        got = '0;
        cnt = 0;
        for (int i = 0; i < 5 * FW; i++) begin
            step(1'b0, 1'b0, 8'h00);
            if (active === 1'b1) begin
                cnt++;
                got = (got << 1) | 64'(data_out);
            end
        end
        expv = '0;
        for (int i = 1; i <= 4; i++) expv = (expv << FW) | frame_of(8'(i));
        chk("ovf_cycles", 64'(cnt), 64'(4 * FW));
        chk("ovf_data", got, expv);
        chk("ovf_sticky", 64'(overflow), 64'(1));

        // Reset in the middle of a data symbol with two words still queued.
        step(1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b1, 8'h22);
        step(1'b0, 1'b1, 8'h33);
        ok = 1'b0;
        for (int i = 0; i < 4 * FW && !ok; i++) begin
            step(1'b0, 1'b0, 8'h00);
            ok = cur_data && (((n - 1) % FW) == 3) && (mq.size() == 2);
        end
        chk("midrst_align", 64'(ok), 64'(1));
        step(1'b1, 1'b0, 8'h00);
        chk("midrst_data_out",   64'(data_out),   64'(0));
        chk("midrst_overflow",   64'(overflow),   64'(0));
        chk("midrst_fifo_empty", 64'(fifo_empty), 64'(1));
        expv = '0;
        for (int i = 0; i < SYNC; i++) expv = (expv << FW) | frame_of(IDLE);
        got = '0;
        for (int i = 0; i < SYNC * FW; i++) begin
            step(1'b0, 1'b0, 8'h00);
            got = (got << 1) | 64'(data_out);
        end
        chk("midrst_resync", got, expv);
        cnt = 0;
        for (int i = 0; i < 4 * FW; i++) begin
            step(1'b0, 1'b0, 8'h00);
            if (active === 1'b1) cnt++;
        end
        chk("midrst_no_stale_data", 64'(cnt), 64'(0));

        // Random traffic: alternating light and heavy load with rare resets.
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 499) == 0);
            pct = ((i / 500) % 2 == 1) ? 85 : 20;
            step(r, ($urandom_range(0, 99) < pct), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
